// File: rtl/alu_seq_core.sv
// alu_seq_core
//   Handshaked ALU with a persistent {E,V,N,Z,C} flag register and an
//   iterative shift-add multiplier.
//   Input transfer:  in_valid && in_ready on a rising clk edge.
//   Output transfer: out_valid && out_ready on a rising clk edge.
//   A producer holds its payload until the transfer, and result/result_hi/flags
//   stay stable while out_valid is high and out_ready is low.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (A = src, B = dst, sel, byte_mode)
//   out_valid/out_ready result handshake (result, result_hi, flags)
//   dbg_state           current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module alu_seq_core #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SEL_W-1:0] sel,
    input  logic             byte_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(0);
    localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(1);
    localparam logic [SEL_W-1:0] OP_ADDC = SEL_W'(2);
    localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(4);
    localparam logic [SEL_W-1:0] OP_SUBC = SEL_W'(5);
    localparam logic [SEL_W-1:0] OP_BIT  = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_BIC  = SEL_W'(7);
    localparam logic [SEL_W-1:0] OP_BIS  = SEL_W'(8);
    localparam logic [SEL_W-1:0] OP_CMP  = SEL_W'(9);
    localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(10);
    localparam int               CNT_W   = $clog2(WIDTH + 1);

    state_t             state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic [4:0]         flags_q;
    logic [WIDTH-1:0]   mcand_q, mul_hi_q, mul_lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mul_byte_q;

    // Single-cycle ALU datapath
    logic [WIDTH-1:0]   mask, a_m, b_m, add_y, logic_r, val, alu_res_d;
    logic [WIDTH:0]     sum;
    logic [4:0]         alu_flags_d;
    logic               is_sub, is_arith, is_logic, cin;
    logic               carry, msb_x, msb_y, msb_r, ovf, zero;

    always_comb begin
        mask     = byte_mode ? WIDTH'(8'hFF) : '1;
        a_m      = A & mask;
        b_m      = B & mask;
        is_sub   = (sel == OP_SUB) || (sel == OP_SUBC) || (sel == OP_CMP);
        is_arith = is_sub || (sel == OP_ADD) || (sel == OP_ADDC);
        is_logic = (sel == OP_AND) || (sel == OP_XOR) || (sel == OP_BIT) ||
                   (sel == OP_BIC) || (sel == OP_BIS);
        // Subtraction is B + ~A + cin; cin=1 gives plain B-A, SUBC uses stored C.
        add_y    = is_sub ? (~A & mask) : a_m;
        cin      = 1'b0;
        if ((sel == OP_SUB) || (sel == OP_CMP)) cin = 1'b1;
        if ((sel == OP_ADDC) || (sel == OP_SUBC)) cin = flags_q[0];
        sum      = {1'b0, b_m} + {1'b0, add_y} + {{WIDTH{1'b0}}, cin};

        logic_r = '0;
        case (sel)
            OP_AND, OP_BIT: logic_r = a_m & b_m;
            OP_XOR:         logic_r = a_m ^ b_m;
            OP_BIC:         logic_r = b_m & ~a_m;
            OP_BIS:         logic_r = a_m | b_m;
            default:        logic_r = '0;
        endcase

        val = is_arith ? (sum[WIDTH-1:0] & mask) : logic_r;
        if (byte_mode) begin
            carry = sum[8];
            msb_x = b_m[7];
            msb_y = add_y[7];
            msb_r = val[7];
        end else begin
            carry = sum[WIDTH];
            msb_x = b_m[WIDTH-1];
            msb_y = add_y[WIDTH-1];
            msb_r = val[WIDTH-1];
        end
        // Overflow: both adder operands share a sign that the sum does not.
        ovf  = (msb_x == msb_y) && (msb_r != msb_x);
        zero = (val == '0);

        if (is_arith)      alu_flags_d = {1'b0, ovf, msb_r, zero, carry};
        else if (is_logic) alu_flags_d = {1'b0, 1'b0, msb_r, zero, ~zero};
        else               alu_flags_d = {1'b1, flags_q[3:0]};

        alu_res_d = ((is_arith || is_logic) && (sel != OP_BIT) && (sel != OP_CMP)) ? val : '0;
    end

    // Multiplier step and final product
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] product;
    logic [4:0]         mul_flags;

    always_comb begin
        mul_sum = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mcand_q} : '0);
        product = {mul_hi_q, mul_lo_q};
        if (mul_byte_q)
            mul_flags = {3'b000, product == '0, |product[15:8]};
        else
            mul_flags = {3'b000, product == '0, |mul_hi_q};
        mul_flags[2] = mul_byte_q ? product[15] : product[2*WIDTH-1];
    end

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            mcand_q     <= '0;
            mul_hi_q    <= '0;
            mul_lo_q    <= '0;
            cnt_q       <= '0;
            mul_byte_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (in_valid && in_ready) begin
                        if (sel == OP_MUL) begin
                            mcand_q     <= a_m;
                            mul_lo_q    <= b_m;
                            mul_hi_q    <= '0;
                            cnt_q       <= '0;
                            mul_byte_q  <= byte_mode;
                            out_valid_q <= 1'b0;
                            state_q     <= S_BUSY;
                        end else begin
                            result_q    <= alu_res_d;
                            result_hi_q <= '0;
                            flags_q     <= alu_flags_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != CNT_W'(WIDTH)) begin
                        // Add-if-set then shift the {hi,lo} pair right by one.
                        {mul_hi_q, mul_lo_q} <= {mul_sum, mul_lo_q[WIDTH-1:1]};
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        result_q    <= product[WIDTH-1:0];
                        result_hi_q <= mul_byte_q ? '0 : mul_hi_q;
                        flags_q     <= mul_flags;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
